// File: rtl/core_mem_responder_pkg.sv
// Shared types and defaults for the core memory responder (package core_mem_pkg).
// LOADER_DMEM_EN adds a loader target select so the loader can fill dmem instead of imem.
package core_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } ld_state_e;

    localparam int          IMEM_DEPTH_DEF = 256;
    localparam int          DMEM_DEPTH_DEF = 256;
    localparam logic [31:0] NOP_WORD_DEF   = 32'h0000_0013;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One bit wider than the largest index, so the write address can reach DEPTH.
    function automatic int loader_aw(input int depth_a, input int depth_b);
        return idx_width((depth_a > depth_b) ? depth_a : depth_b) + 1;
    endfunction

endpackage

// File: rtl/core_mem_responder_if.sv
// Bus bundle between the core/pads (master) and the memory responder (slave).
// LOADER_DMEM_EN adds the ld_target select line.
interface core_mem_responder_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_we;
    logic [31:0] dmem_rdata;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_ready;
    logic        ld_done;
    logic        ld_overflow;
    logic        core_hold;
`ifdef LOADER_DMEM_EN
    logic        ld_target;
`endif

    modport master (
`ifdef LOADER_DMEM_EN
        output ld_target,
`endif
        output imem_addr, dmem_addr, dmem_wdata, dmem_we,
        output ld_start, ld_valid, ld_byte,
        input  imem_rdata, dmem_rdata, ld_ready, ld_done, ld_overflow, core_hold
    );

    modport slave (
`ifdef LOADER_DMEM_EN
        input  ld_target,
`endif
        input  imem_addr, dmem_addr, dmem_wdata, dmem_we,
        input  ld_start, ld_valid, ld_byte,
        output imem_rdata, dmem_rdata, ld_ready, ld_done, ld_overflow, core_hold
    );
endinterface

// File: rtl/core_mem_responder_byte_word_loader.sv
// Byte-serial program loader: assembles little-endian words and emits word writes.
// LOADER_DMEM_EN adds ld_target_i, sampled at session start, to steer words to dmem.
module byte_word_loader
    import core_mem_pkg::*;
#(
    parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
    parameter int DMEM_DEPTH = DMEM_DEPTH_DEF,
    localparam int AW = loader_aw(IMEM_DEPTH, DMEM_DEPTH)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          ld_start_i,
    input  logic          ld_valid_i,
    input  logic [7:0]    ld_byte_i,
`ifdef LOADER_DMEM_EN
    input  logic          ld_target_i,
`endif
    output logic          ld_ready_o,
    output logic          ld_done_o,
    output logic          ld_overflow_o,
    output logic          core_hold_o,
    output logic          wr_en_o,
    output logic          wr_dmem_o,
    output logic [AW-2:0] wr_addr_o,
    output logic [31:0]   wr_data_o
);

    ld_state_e       state_q, state_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [23:0]     lanes_q, lanes_d;
    logic            overflow_q, overflow_d;
    logic            target_q, target_d;
    logic            emit_s;
    logic            wr_en_s;
    logic [31:0]     wr_data_s;
    logic [AW-1:0]   limit_s;

`ifdef LOADER_DMEM_EN
    assign limit_s = target_q ? AW'(DMEM_DEPTH) : AW'(IMEM_DEPTH);
`else
    assign limit_s = AW'(IMEM_DEPTH);
`endif

    // Loader state and datapath registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= ST_IDLE;
            waddr_q    <= '0;
            byte_cnt_q <= 2'd0;
            lanes_q    <= 24'h00_0000;
            overflow_q <= 1'b0;
            target_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            waddr_q    <= waddr_d;
            byte_cnt_q <= byte_cnt_d;
            lanes_q    <= lanes_d;
            overflow_q <= overflow_d;
            target_q   <= target_d;
        end
    end

    // Next-state, byte lane assembly and word emission.
    always_comb begin
        state_d    = state_q;
        waddr_d    = waddr_q;
        byte_cnt_d = byte_cnt_q;
        lanes_d    = lanes_q;
        overflow_d = overflow_q;
        target_d   = target_q;
        emit_s     = 1'b0;
        wr_en_s    = 1'b0;
        wr_data_s  = {8'h00, lanes_q};

        case (state_q)
            ST_IDLE: begin
                if (ld_start_i) begin
                    state_d    = ST_LOAD;
                    waddr_d    = '0;
                    byte_cnt_d = 2'd0;
                    lanes_d    = 24'h00_0000;
                    overflow_d = 1'b0;
`ifdef LOADER_DMEM_EN
                    target_d   = ld_target_i;
`else
                    target_d   = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // A byte offered in the cycle ld_start drops is not taken.
                if (!ld_start_i) begin
                    state_d = (byte_cnt_q == 2'd0) ? ST_DONE : ST_FLUSH;
                end else if (ld_valid_i) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0: lanes_d[7:0]   = ld_byte_i;
                        2'd1: lanes_d[15:8]  = ld_byte_i;
                        2'd2: lanes_d[23:16] = ld_byte_i;
                        2'd3: begin
                            emit_s    = 1'b1;
                            wr_data_s = {ld_byte_i, lanes_q};
                            lanes_d   = 24'h00_0000;
                        end
                        default: lanes_d = lanes_q;
                    endcase
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_FLUSH: begin
                emit_s     = 1'b1;
                wr_data_s  = {8'h00, lanes_q};
                lanes_d    = 24'h00_0000;
                byte_cnt_d = 2'd0;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Past the array end the word is dropped and waddr parks at DEPTH.
        if (emit_s) begin
            if (waddr_q >= limit_s) begin
                overflow_d = 1'b1;
            end else begin
                wr_en_s = 1'b1;
                waddr_d = waddr_q + AW'(1);
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    assign ld_ready_o    = (state_q == ST_LOAD);
    assign ld_done_o     = (state_q == ST_DONE);
    assign core_hold_o   = (state_q != ST_IDLE);
    assign ld_overflow_o = overflow_q;
    assign wr_en_o       = wr_en_s;
    assign wr_dmem_o     = target_q;
    assign wr_addr_o     = waddr_q[AW-2:0];
    assign wr_data_o     = wr_data_s;

endmodule

// File: rtl/core_mem_responder.sv
// Instruction/data memory responder with combinational reads and a byte-serial loader.
// LOADER_DMEM_EN lets a loading session target dmem via bus.ld_target.
module core_mem_responder
    import core_mem_pkg::*;
#(
    parameter int          IMEM_DEPTH = IMEM_DEPTH_DEF,
    parameter int          DMEM_DEPTH = DMEM_DEPTH_DEF,
    parameter logic [31:0] NOP_WORD   = NOP_WORD_DEF
) (
    input logic                 clk,
    input logic                 clr,
    core_mem_responder_if.slave bus
);

    localparam int IIW = idx_width(IMEM_DEPTH);
    localparam int DIW = idx_width(DMEM_DEPTH);
    localparam int LAW = loader_aw(IMEM_DEPTH, DMEM_DEPTH);

    logic [31:0]    imem_q [IMEM_DEPTH];
    logic [31:0]    dmem_q [DMEM_DEPTH];

    logic           hold_s;
    logic           ld_wr_en_s;
    logic           ld_wr_dmem_s;
    logic [LAW-2:0] ld_wr_addr_s;
    logic [31:0]    ld_wr_data_s;
    logic [IIW-1:0] imem_idx_s;
    logic [DIW-1:0] dmem_idx_s;
    logic           imem_oob_s;
    logic           dmem_oob_s;
    logic           core_we_s;
    logic [31:0]    imem_rdata_s;
    logic [31:0]    dmem_rdata_s;

    byte_word_loader #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .DMEM_DEPTH (DMEM_DEPTH)
    ) u_loader (
        .clk           (clk),
        .clr           (clr),
        .ld_start_i    (bus.ld_start),
        .ld_valid_i    (bus.ld_valid),
        .ld_byte_i     (bus.ld_byte),
`ifdef LOADER_DMEM_EN
        .ld_target_i   (bus.ld_target),
`endif
        .ld_ready_o    (bus.ld_ready),
        .ld_done_o     (bus.ld_done),
        .ld_overflow_o (bus.ld_overflow),
        .core_hold_o   (hold_s),
        .wr_en_o       (ld_wr_en_s),
        .wr_dmem_o     (ld_wr_dmem_s),
        .wr_addr_o     (ld_wr_addr_s),
        .wr_data_o     (ld_wr_data_s)
    );

    assign imem_idx_s = bus.imem_addr[IIW-1:0];
    assign dmem_idx_s = bus.dmem_addr[DIW-1:0];
    assign imem_oob_s = ((bus.imem_addr >> IIW) != 32'd0);
    assign dmem_oob_s = ((bus.dmem_addr >> DIW) != 32'd0);
    assign core_we_s  = bus.dmem_we && !hold_s && !dmem_oob_s;

    // Instruction array write port, owned by the loader.
    always_ff @(posedge clk) begin
        if (ld_wr_en_s && !ld_wr_dmem_s) begin
            imem_q[ld_wr_addr_s[IIW-1:0]] <= ld_wr_data_s;
        end
    end

    // Data array write port: loader words win, core stores only outside hold.
    always_ff @(posedge clk) begin
        if (ld_wr_en_s && ld_wr_dmem_s) begin
            dmem_q[ld_wr_addr_s[DIW-1:0]] <= ld_wr_data_s;
        end else if (core_we_s) begin
            dmem_q[dmem_idx_s] <= bus.dmem_wdata;
        end
    end

    // Zero-latency read muxing with hold and out-of-range substitution.
    always_comb begin
        imem_rdata_s = 32'h0000_0000;
        dmem_rdata_s = 32'h0000_0000;
        if (hold_s) begin
            imem_rdata_s = NOP_WORD;
        end else if (imem_oob_s) begin
            imem_rdata_s = 32'h0000_0000;
        end else begin
            imem_rdata_s = imem_q[imem_idx_s];
        end
        if (dmem_oob_s) begin
            dmem_rdata_s = 32'h0000_0000;
        end else begin
            dmem_rdata_s = dmem_q[dmem_idx_s];
        end
    end

    assign bus.imem_rdata = imem_rdata_s;
    assign bus.dmem_rdata = dmem_rdata_s;
    assign bus.core_hold  = hold_s;

endmodule

// File: tb/tb_core_mem_responder.sv
// Directed self-checking bench for core_mem_responder (default 256-word depths).
module tb_core_mem_responder;

    logic clk;
    logic clr;
    int   tests_run;
    int   fails;

    core_mem_responder_if bus_if ();

    core_mem_responder dut (
        .clk (clk),
        .clr (clr),
        .bus (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word_of(input int i);
        logic [31:0] v;
        v = i;
        return (v * 32'h0101_0101) ^ 32'h1234_5678;
    endfunction

    task automatic start_session();
        bus_if.ld_start = 1'b1;
        bus_if.ld_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus_if.ld_valid = 1'b1;
        bus_if.ld_byte  = b;
        @(negedge clk);
        bus_if.ld_valid = 1'b0;
    endtask

    task automatic chk_imem(input string name, input logic [31:0] addr, input logic [31:0] exp);
        bus_if.imem_addr = addr;
        #1;
        tests_run++;
        if (bus_if.imem_rdata !== exp) begin
            fails++;
            $display("FAIL %s: imem_rdata got %h expected %h", name, bus_if.imem_rdata, exp);
        end
    endtask

    task automatic chk_dmem(input string name, input logic [31:0] addr, input logic [31:0] exp);
        bus_if.dmem_addr = addr;
        #1;
        tests_run++;
        if (bus_if.dmem_rdata !== exp) begin
            fails++;
            $display("FAIL %s: dmem_rdata got %h expected %h", name, bus_if.dmem_rdata, exp);
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({bus_if.core_hold, bus_if.ld_ready, bus_if.ld_done, bus_if.ld_overflow} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags: hold/ready/done/ovf got %b expected 0000",
                     {bus_if.core_hold, bus_if.ld_ready, bus_if.ld_done, bus_if.ld_overflow});
        end
        chk_imem("imem_oob_0x100", 32'h0000_0100, 32'h0000_0000);
        chk_imem("imem_oob_msb", 32'h8000_0000, 32'h0000_0000);
        chk_dmem("dmem_oob_0x200", 32'h0000_0200, 32'h0000_0000);
    endtask

    task automatic test_load_words();
        logic [7:0] bytes [8];
        int nop_bad;
        bytes = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        nop_bad = 0;
        bus_if.imem_addr = 32'h0000_0000;
        start_session();
        tests_run++;
        if ({bus_if.core_hold, bus_if.ld_ready} !== 2'b11) begin
            fails++;
            $display("FAIL load_enter: hold/ready got %b expected 11", {bus_if.core_hold, bus_if.ld_ready});
        end
        for (int i = 0; i < 8; i++) begin
            if (bus_if.imem_rdata !== 32'h0000_0013) nop_bad++;
            send_byte(bytes[i]);
        end
        tests_run++;
        if (nop_bad != 0) begin
            fails++;
            $display("FAIL nop_during_hold: %0d non-NOP reads, expected 0", nop_bad);
        end
        bus_if.ld_start = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({bus_if.ld_done, bus_if.core_hold, bus_if.ld_ready} !== 3'b110) begin
            fails++;
            $display("FAIL done_pulse: done/hold/ready got %b expected 110",
                     {bus_if.ld_done, bus_if.core_hold, bus_if.ld_ready});
        end
        @(negedge clk);
        tests_run++;
        if ({bus_if.ld_done, bus_if.core_hold} !== 2'b00) begin
            fails++;
            $display("FAIL done_end: done/hold got %b expected 00", {bus_if.ld_done, bus_if.core_hold});
        end
        chk_imem("imem0_word", 32'd0, 32'h0000_0013);
        chk_imem("imem1_word", 32'd1, 32'h0010_0093);
    endtask

    task automatic test_flush();
        logic [7:0] bytes [6];
        bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        @(negedge clk);
        start_session();
        for (int i = 0; i < 6; i++) send_byte(bytes[i]);
        // A byte offered as ld_start drops must be ignored.
        bus_if.ld_start = 1'b0;
        bus_if.ld_valid = 1'b1;
        bus_if.ld_byte  = 8'h77;
        @(negedge clk);
        bus_if.ld_valid = 1'b0;
        tests_run++;
        if ({bus_if.ld_done, bus_if.core_hold, bus_if.ld_ready} !== 3'b010) begin
            fails++;
            $display("FAIL flush_state: done/hold/ready got %b expected 010",
                     {bus_if.ld_done, bus_if.core_hold, bus_if.ld_ready});
        end
        @(negedge clk);
        tests_run++;
        if (bus_if.ld_done !== 1'b1) begin
            fails++;
            $display("FAIL flush_done: ld_done got %b expected 1", bus_if.ld_done);
        end
        @(negedge clk);
        chk_imem("flush_imem0", 32'd0, 32'hDDCC_BBAA);
        chk_imem("flush_imem1", 32'd1, 32'h0000_2211);
    endtask

    task automatic test_core_store();
        bus_if.dmem_addr  = 32'd5;
        bus_if.dmem_wdata = 32'h1111_1111;
        bus_if.dmem_we    = 1'b1;
        @(negedge clk);
        bus_if.dmem_wdata = 32'hCAFE_F00D;
        #1;
        tests_run++;
        if (bus_if.dmem_rdata !== 32'h1111_1111) begin
            fails++;
            $display("FAIL read_old_same_cycle: dmem_rdata got %h expected 11111111", bus_if.dmem_rdata);
        end
        @(negedge clk);
        bus_if.dmem_we = 1'b0;
        chk_dmem("store_readback", 32'd5, 32'hCAFE_F00D);
        bus_if.dmem_addr  = 32'd0;
        bus_if.dmem_wdata = 32'hA5A5_A5A5;
        bus_if.dmem_we    = 1'b1;
        @(negedge clk);
        bus_if.dmem_addr  = 32'h0000_0100;
        bus_if.dmem_wdata = 32'h1234_5678;
        @(negedge clk);
        bus_if.dmem_we = 1'b0;
        chk_dmem("oob_store_read", 32'h0000_0100, 32'h0000_0000);
        chk_dmem("oob_no_alias", 32'd0, 32'hA5A5_A5A5);
        // Stores during hold are ignored.
        @(negedge clk);
        start_session();
        bus_if.dmem_addr  = 32'd5;
        bus_if.dmem_wdata = 32'hDEAD_BEEF;
        bus_if.dmem_we    = 1'b1;
        @(negedge clk);
        bus_if.dmem_we  = 1'b0;
        bus_if.ld_start = 1'b0;
        repeat (3) @(negedge clk);
        chk_dmem("store_during_hold", 32'd5, 32'hCAFE_F00D);
    endtask

    task automatic test_overflow();
        logic [31:0] w;
        int bad;
        start_session();
        for (int i = 0; i < 257; i++) begin
            w = word_of(i);
            for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
            if (i == 255) begin
                tests_run++;
                if (bus_if.ld_overflow !== 1'b0) begin
                    fails++;
                    $display("FAIL ovf_early: ld_overflow got %b expected 0 after 256 words", bus_if.ld_overflow);
                end
            end
        end
        tests_run++;
        if (bus_if.ld_overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_set: ld_overflow got %b expected 1", bus_if.ld_overflow);
        end
        bus_if.ld_start = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({bus_if.ld_overflow, bus_if.core_hold} !== 2'b10) begin
            fails++;
            $display("FAIL ovf_sticky: ovf/hold got %b expected 10", {bus_if.ld_overflow, bus_if.core_hold});
        end
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            bus_if.imem_addr = i;
            #1;
            if (bus_if.imem_rdata !== word_of(i)) begin
                if (bad == 0) $display("FAIL ovf_contents: imem[%0d] got %h expected %h",
                                       i, bus_if.imem_rdata, word_of(i));
                bad++;
            end
        end
        tests_run++;
        if (bad != 0) begin
            fails++;
            $display("FAIL ovf_contents_total: %0d bad words, expected 0", bad);
        end
        chk_imem("ovf_imem0_kept", 32'd0, 32'h1234_5678);
        @(negedge clk);
        start_session();
        tests_run++;
        if (bus_if.ld_overflow !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clear: ld_overflow got %b expected 0 at new session", bus_if.ld_overflow);
        end
        bus_if.ld_start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_clr_mid_session();
        start_session();
        send_byte(8'hAB);
        send_byte(8'hCD);
        clr = 1'b1;
        #1;
        tests_run++;
        if ({bus_if.core_hold, bus_if.ld_ready} !== 2'b00) begin
            fails++;
            $display("FAIL clr_immediate: hold/ready got %b expected 00", {bus_if.core_hold, bus_if.ld_ready});
        end
        @(negedge clk);
        clr = 1'b0;
        bus_if.ld_start = 1'b0;
        @(negedge clk);
        start_session();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        bus_if.ld_start = 1'b0;
        repeat (2) @(negedge clk);
        chk_imem("clr_restart_waddr0", 32'd0, 32'h0403_0201);
        chk_imem("clr_words_kept", 32'd1, word_of(1));
    endtask

    initial begin
        tests_run         = 0;
        fails             = 0;
        clr               = 1'b1;
        bus_if.imem_addr  = 32'd0;
        bus_if.dmem_addr  = 32'd0;
        bus_if.dmem_wdata = 32'd0;
        bus_if.dmem_we    = 1'b0;
        bus_if.ld_start   = 1'b0;
        bus_if.ld_valid   = 1'b0;
        bus_if.ld_byte    = 8'h00;
`ifdef LOADER_DMEM_EN
        bus_if.ld_target  = 1'b0;
`endif
        test_reset();
        test_load_words();
        test_flush();
        test_core_store();
        test_overflow();
        test_clr_mid_session();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
